// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a first-word-fall-through fifo.
// Each frame is a start bit, LSB-first data, optional parity, then stop bit(s).
`timescale 1ns/1ps
module fifo_uart_tx #(
  parameter int bitWidth     = 8,
  parameter int clocksPerBit = 16,
  parameter int parityEnable = 0,
  parameter int parityOdd    = 0,
  parameter int stopBits     = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                empty,
  input  logic [bitWidth-1:0] popData,
  output logic                pop,
  output logic                txd,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int DIV_W = (clocksPerBit > 2) ? $clog2(clocksPerBit) : 1;
  localparam int CNT_W = $clog2(bitWidth + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(clocksPerBit - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(bitWidth - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(stopBits - 1);
  localparam logic             PAR_ODD   = (parityOdd != 0);

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [CNT_W-1:0]    r_bitCnt;
  logic [bitWidth-1:0] r_shift;
  logic                r_parity;
  logic                r_txd;
  logic                r_busy;

  state_t              w_nextState;
  logic [DIV_W-1:0]    w_nextDiv;
  logic [CNT_W-1:0]    w_nextBitCnt;
  logic [bitWidth-1:0] w_nextShift;
  logic                w_nextParity;
  logic                w_nextTxd;
  logic                w_bitDone;
  logic                w_pop;

  assign w_bitDone = (r_div == DIV_LAST);

  // Parity is captured at pop time because the shift register is consumed while sending.
  always_comb begin
    w_nextState  = r_state;
    w_nextBitCnt = r_bitCnt;
    w_nextShift  = r_shift;
    w_nextParity = r_parity;
    w_nextDiv    = (r_state == IDLE || w_bitDone) ? '0 : r_div + 1'b1;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop = enable & ~empty;
      end
      START: begin
        if (w_bitDone) begin
          w_nextState  = DATA;
          w_nextBitCnt = '0;
        end
      end
      DATA: begin
        if (w_bitDone) begin
          w_nextShift = r_shift >> 1;
          if (r_bitCnt == DATA_LAST) begin
            w_nextBitCnt = '0;
            w_nextState  = (parityEnable != 0) ? PARITY : STOP;
          end else begin
            w_nextBitCnt = r_bitCnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bitDone) begin
          w_nextState  = STOP;
          w_nextBitCnt = '0;
        end
      end
      STOP: begin
        if (w_bitDone) begin
          if (r_bitCnt == STOP_LAST) begin
            w_nextBitCnt = '0;
            w_pop        = enable & ~empty;
            w_nextState  = IDLE;
          end else begin
            w_nextBitCnt = r_bitCnt + 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (w_pop) begin
      w_nextState  = START;
      w_nextShift  = popData;
      w_nextParity = (^popData) ^ PAR_ODD;
      w_nextBitCnt = '0;
    end
  end

  always_comb begin
    w_nextTxd = 1'b1;
    case (w_nextState)
      START:   w_nextTxd = 1'b0;
      DATA:    w_nextTxd = w_nextShift[0];
      PARITY:  w_nextTxd = w_nextParity;
      default: w_nextTxd = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_div    <= w_nextDiv;
      r_bitCnt <= w_nextBitCnt;
      r_shift  <= w_nextShift;
      r_parity <= w_nextParity;
      r_txd    <= w_nextTxd;
      r_busy   <= (w_nextState != IDLE);
    end
  end

  // Gating with reset keeps the fifo untouched while the block is held in reset.
  assign pop  = w_pop & reset;
  assign txd  = r_txd;
  assign busy = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: three parameterisations share one fifo model,
// a serial decoder feeds a scoreboard of expected frames.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  logic       clock;
  logic       reset;
  logic [2:0] en;
  logic       empty;
  logic [7:0] popData;
  logic [2:0] pop;
  logic [2:0] txd;
  logic [2:0] busy;

  // 0: no parity, 1 stop; 1: even parity, 1 stop; 2: odd parity, 2 stops
  fifo_uart_tx #(.bitWidth(8), .clocksPerBit(4), .parityEnable(0), .parityOdd(0), .stopBits(1)) dut0 (
    .clock(clock), .reset(reset), .enable(en[0]), .empty(empty), .popData(popData),
    .pop(pop[0]), .txd(txd[0]), .busy(busy[0]));
  fifo_uart_tx #(.bitWidth(8), .clocksPerBit(4), .parityEnable(1), .parityOdd(0), .stopBits(1)) dut1 (
    .clock(clock), .reset(reset), .enable(en[1]), .empty(empty), .popData(popData),
    .pop(pop[1]), .txd(txd[1]), .busy(busy[1]));
  fifo_uart_tx #(.bitWidth(8), .clocksPerBit(4), .parityEnable(1), .parityOdd(1), .stopBits(2)) dut2 (
    .clock(clock), .reset(reset), .enable(en[2]), .empty(empty), .popData(popData),
    .pop(pop[2]), .txd(txd[2]), .busy(busy[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       chkPar;
    logic       expPar;
    int         expBusy;
  } vec_t;

  int         checks;
  int         failures;
  int         sel;
  logic [7:0] fifoQ[$];
  exp_t       expQ[$];
  int         cyc;
  int         popCnt;
  int         busyCnt;
  int         txdLowCnt;
  int         firstFall;
  int         otherPopCnt;
  int         popCycQ[$];
  logic       prevTxd;
  bit         rxActive;
  int         rxCyc;
  logic [11:0] rxBits;
  logic       lastPar;
  int         cycStart;
  vec_t       vecs[6];

  function automatic int parEn(input int s);
    return (s != 0) ? 1 : 0;
  endfunction

  function automatic int frameBits(input int s);
    return 1 + 8 + parEn(s) + ((s == 2) ? 2 : 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic updFifo();
    empty   = (fifoQ.size() == 0);
    popData = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
  endtask

  task automatic applyStimulus(input logic [7:0] word);
    exp_t e;
    fifoQ.push_back(word);
    e.data = word;
    e.par  = (^word) ^ (sel == 2);
    expQ.push_back(e);
    updFifo();
  endtask

  task automatic resetCounters();
    popCnt    = 0;
    busyCnt   = 0;
    txdLowCnt = 0;
    firstFall = -1;
    popCycQ.delete();
  endtask

  task automatic finishFrame();
    exp_t        e;
    int          n;
    int          pe;
    logic        stopOk;
    logic [10:0] got;
    logic [10:0] want;
    n  = frameBits(sel);
    pe = parEn(sel);
    stopOk = 1'b1;
    for (int i = 9 + pe; i < n; i++) if (!rxBits[i]) stopOk = 1'b0;
    lastPar = (pe != 0) ? rxBits[9] : 1'b0;
    got = {rxBits[0], rxBits[8:1], lastPar, stopOk};
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpectedFrame actual=%0h expected=none", got);
    end else begin
      e = expQ.pop_front();
      want = {1'b0, e.data, (pe != 0) ? e.par : 1'b0, 1'b1};
      checkOutput("frame", 32'(got), 32'(want));
    end
  endtask

  task automatic decode(input logic st);
    if (!rxActive && !st) begin
      rxActive = 1'b1;
      rxCyc    = 0;
      rxBits   = '0;
    end else if (rxActive) begin
      rxCyc++;
    end
    if (rxActive) begin
      if (rxCyc % 4 == 2) rxBits[rxCyc / 4] = st;
      if (rxCyc == frameBits(sel) * 4 - 1) begin
        rxActive = 1'b0;
        finishFrame();
      end
    end
  endtask

  // One clock: sample at the falling edge, let the fifo model react just after the rising edge.
  task automatic tick();
    logic sp;
    logic st;
    logic sb;
    @(negedge clock);
    cyc++;
    sp = pop[sel];
    st = txd[sel];
    sb = busy[sel];
    if ((pop & ~(3'b001 << sel)) != 3'b000) otherPopCnt++;
    if (sp) begin
      popCnt++;
      popCycQ.push_back(cyc);
    end
    if (sb) busyCnt++;
    if (!st) txdLowCnt++;
    if (prevTxd && !st && firstFall < 0) firstFall = cyc;
    prevTxd = st;
    decode(st);
    @(posedge clock);
    #1;
    if (sp && fifoQ.size() > 0) begin
      void'(fifoQ.pop_front());
      updFifo();
    end
  endtask

  initial begin
    checks = 0; failures = 0; sel = 0; cyc = 0; otherPopCnt = 0;
    prevTxd = 1'b1; rxActive = 1'b0; rxCyc = 0; rxBits = '0; lastPar = 1'b0;
    resetCounters();
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 40};
    vecs[1] = '{1, 8'hA5, 1'b1, 1'b0, 44};
    vecs[2] = '{2, 8'hA5, 1'b1, 1'b1, 48};
    vecs[3] = '{1, 8'h07, 1'b1, 1'b1, 44};
    vecs[4] = '{0, 8'hFF, 1'b0, 1'b0, 40};
    vecs[5] = '{2, 8'h00, 1'b1, 1'b1, 48};

    // Reset held with work pending: nothing may pop or transmit.
    reset = 1'b0;
    en = 3'b111;
    fifoQ.push_back(8'h55);
    updFifo();
    repeat (3) @(negedge clock);
    checkOutput("resetTxd", 32'(txd), 32'h7);
    checkOutput("resetBusy", 32'(busy), 32'h0);
    checkOutput("resetPop", 32'(pop), 32'h0);
    en = 3'b000;
    fifoQ.delete();
    updFifo();
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (5) tick();
    checkOutput("idleAfterReset", txdLowCnt, 0);

    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel;
      resetCounters();
      applyStimulus(vecs[i].data);
      en = 3'(1 << sel);
      repeat (vecs[i].expBusy + 8) tick();
      en = 3'b000;
      checkOutput("vecPops", popCnt, 1);
      checkOutput("vecBusy", busyCnt, vecs[i].expBusy);
      checkOutput("vecLatency", (popCycQ.size() > 0) ? firstFall - popCycQ[0] : -1, 1);
      checkOutput("vecScoreboard", expQ.size(), 0);
      if (vecs[i].chkPar) checkOutput("vecParity", 32'(lastPar), 32'(vecs[i].expPar));
    end

    // Three queued words sent back to back.
    sel = 0;
    resetCounters();
    applyStimulus(8'h05);
    applyStimulus(8'h06);
    applyStimulus(8'h07);
    repeat (3) tick();
    checkOutput("b2bNoPopDisabled", popCnt, 0);
    resetCounters();
    en = 3'b001;
    repeat (130) tick();
    checkOutput("b2bPops", popCnt, 3);
    checkOutput("b2bSpacing1", (popCycQ.size() > 1) ? popCycQ[1] - popCycQ[0] : -1, 40);
    checkOutput("b2bSpacing2", (popCycQ.size() > 2) ? popCycQ[2] - popCycQ[1] : -1, 40);
    checkOutput("b2bBusy", busyCnt, 120);
    checkOutput("b2bEmpty", 32'(empty), 1);
    checkOutput("b2bScoreboard", expQ.size(), 0);

    // Enabled but empty for 100 cycles, then one word arrives.
    resetCounters();
    repeat (100) tick();
    checkOutput("emptyPops", popCnt, 0);
    checkOutput("emptyTxdLow", txdLowCnt, 0);
    checkOutput("emptyBusy", busyCnt, 0);
    resetCounters();
    cycStart = cyc;
    applyStimulus(8'h3C);
    repeat (45) tick();
    checkOutput("emptyStartLatency", 32'((firstFall >= 0) && (firstFall - cycStart <= 2)), 1);
    checkOutput("emptyScoreboard", expQ.size(), 0);

    // Asynchronous reset in the middle of a frame.
    resetCounters();
    applyStimulus(8'h5A);
    tick();
    repeat (15) tick();
    #2;
    checkOutput("midPreResetTxd", 32'(txd[0]), 0);
    reset = 1'b0;
    #1;
    checkOutput("midResetTxd", 32'(txd[0]), 1);
    checkOutput("midResetBusy", 32'(busy[0]), 0);
    void'(expQ.pop_front());
    rxActive = 1'b0;
    prevTxd  = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1;
    resetCounters();
    repeat (60) tick();
    checkOutput("postResetTxdLow", txdLowCnt, 0);
    checkOutput("postResetBusy", busyCnt, 0);
    checkOutput("postResetPops", popCnt, 0);
    en = 3'b000;

    // Two stop bits; enable dropped mid-DATA with more words waiting.
    sel = 2;
    resetCounters();
    applyStimulus(8'h81);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    en = 3'b100;
    tick();
    repeat (12) tick();
    en = 3'b000;
    repeat (60) tick();
    checkOutput("stop2Pops", popCnt, 1);
    checkOutput("stop2Busy", busyCnt, 48);
    checkOutput("stop2Pending", expQ.size(), 2);
    resetCounters();
    cycStart = cyc;
    en = 3'b100;
    repeat (110) tick();
    checkOutput("reEnablePops", popCnt, 2);
    checkOutput("reEnableLatency", (popCycQ.size() > 0) ? popCycQ[0] - cycStart : -1, 1);
    checkOutput("reEnableSpacing", (popCycQ.size() > 1) ? popCycQ[1] - popCycQ[0] : -1, 48);
    checkOutput("reEnableScoreboard", expQ.size(), 0);
    checkOutput("reEnableEmpty", 32'(empty), 1);
    checkOutput("otherPops", otherPopCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's fifo block. It drains words from the fifo's pop port and serializes each word onto a single asynchronous serial line: start bit, data LSB-first, optional parity, stop bit(s). It sits between a fifo instance (bitWidth 8) and an off-chip TX pin. It is the transmit counterpart of the push-side producer that fills the fifo.

Parameters:
bitWidth, 8, data bits per frame; must match the fifo bitWidth.
clocksPerBit, 16, clock cycles per serial bit (baud divider); ≥ 2.
parityEnable, 0, 1 = insert a parity bit after the data bits.
parityOdd, 0, 1 = odd parity, 0 = even parity; ignored when parityEnable = 0.
stopBits, 1, number of stop bits, 1 or 2.

Ports:
clock  input  1  system clock, rising-edge.
reset  input  1  reset, asynchronous, active-low.
enable  input  1  1 = block may start new frames; sampled only in IDLE and in the last stop-bit cycle.
empty  input  1  fifo empty flag.
popData  input  bitWidth  fifo head word; first-word-fall-through, valid whenever empty = 0.
pop  output  1  one-cycle pop strobe to the fifo.
txd  output  1  serial line; idle high.
busy  output  1  1 while a frame is in progress (START through STOP).

Behaviour:
- Reset (reset = 0) asynchronously forces: state IDLE, txd = 1, pop = 0, busy = 0; bit counter, divider and shift register = 0. Reset mid-frame aborts the frame, with no partial retransmit after release.
- txd and busy are registered. pop is combinational from the registered state, enable and empty.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: pop = enable & ~empty. In a cycle with pop = 1, latch popData into the shift register and go to START on the next edge. txd falls on that edge, 1 cycle after the pop cycle.
- Each bit state holds txd for exactly clocksPerBit cycles. A divider counts 0 .. clocksPerBit-1; the state or bit advances when the divider reaches clocksPerBit-1.
- START: txd = 0 → DATA.
- DATA: txd = shift[0]. The register shifts right at each bit boundary. After bitWidth bits → PARITY if parityEnable, else STOP.
- PARITY: txd = XOR of all data bits, XOR parityOdd → STOP.
- STOP: txd = 1 for stopBits × clocksPerBit cycles.
- In the final cycle of the last stop bit:
  - If enable & ~empty: pop = 1, latch popData, go to START. This gives back-to-back frames with no idle gap.
  - Otherwise go to IDLE, with busy = 0 on that edge.
- pop is never asserted when empty = 1, and never outside IDLE or the last stop cycle. Exactly one pop per transmitted frame.
- enable deasserted mid-frame: the current frame completes normally. No further pop occurs until enable = 1.
- Frame length = (1 + bitWidth + parityEnable + stopBits) × clocksPerBit cycles.
- busy = 1 from the START entry edge through the last STOP cycle. Between back-to-back frames busy stays 1.

Test Plan:
- clocksPerBit=4, no parity, 1 stop; push 0xA5, enable=1 → pop pulses once; txd = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), 4 cycles each; busy high for exactly 40 cycles; txd falls 1 cycle after pop.
- parityEnable=1, parityOdd=0, push 0xA5 → parity bit 0, frame 44 cycles. With parityOdd=1 → parity bit 1. Push 0x07, even parity → parity bit 1.
- Push 0x05, 0x06, 0x07 before enable, then enable=1 → 3 pop pulses spaced exactly 40 cycles apart; txd never idles high between frames beyond the stop bit; busy stays 1 for 120 cycles; then the fifo reports empty.
- empty=1 with enable=1 for 100 cycles → pop never asserts, txd = 1, busy = 0. Push 0x3C → frame starts within 2 cycles.
- Assert reset low at cycle 15 of a frame (mid-DATA) → txd = 1 and busy = 0 immediately, without waiting for a clock edge. After release, with the fifo empty, no further txd activity occurs.
- stopBits=2, enable dropped during DATA of 0x81 with more words queued → frame completes with 8 stop-high cycles (clocksPerBit=4); no second pop while enable = 0. Re-enable → next pop occurs.
